// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU scheduler slice.
//   operation_t   : ALU opcode carried on req_op / alu_op
//   ALU_LAT       : default alu2 input-to-output latency
//   sched_state_t : scheduler FSM state encoding
package alu_pkg;

    localparam int unsigned OP_W    = 2;
    localparam int unsigned ALU_LAT = 2;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } operation_t;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE  = 2'd0;
    localparam sched_state_t ST_RUN   = 2'd1;
    localparam sched_state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal rotating pointer.
//   clk, rst_n    : clock, async active-low reset
//   req           : request vector
//   advance       : 1 = grants allowed this cycle (pointer may move)
//   grant_onehot  : one-hot grant, zero when advance=0 or no request
//   grant_idx     : index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant_onehot,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] idx;
    logic          found;

    // Search from ptr upward, wrapping N-1 -> 0; first hit wins.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        idx          = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IW'((32'(ptr_q) + i) % N);
            if (advance && !found && req[idx]) begin
                found             = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_idx         = idx;
            end
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = IW'((32'(grant_idx) + 32'd1) % N);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// Shares one external alu2 (fixed latency, no backpressure) among NREQ requesters.
// The integrator drives alu2 rst from ~rst_n.
//   clk, rst_n    : clock, async active-low reset
//   en            : 1 = grants allowed; 0 = drain in-flight ops and stop
//   req_valid/op/a/b : per-requester request (slice i of each bus)
//   req_ready     : one-hot grant (combinational)
//   resp_valid    : one-hot result strobe, resp_data valid while |resp_valid
//   idle          : FSM in IDLE (nothing in flight)
//   alu_op/a/b/in_valid : issue port to alu2 (combinational, alu2 registers inputs)
//   alu_out       : alu2 result
module alu_sched #(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ALU_LAT = alu_pkg::ALU_LAT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*2-1:0]       req_op,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         resp_valid,
    output logic [WIDTH-1:0]        resp_data,
    output logic                    idle,
    output logic [1:0]              alu_op,
    output logic [WIDTH-1:0]        alu_a,
    output logic [WIDTH-1:0]        alu_b,
    output logic                    alu_in_valid,
    input  logic [WIDTH-1:0]        alu_out
);

    localparam int unsigned IW  = $clog2(NREQ);
    localparam int unsigned OPW = alu_pkg::OP_W;

    alu_pkg::sched_state_t state_q;
    alu_pkg::sched_state_t state_d;

    logic [NREQ-1:0]    grant_oh;
    logic [IW-1:0]      grant_idx;
    logic               grant_en;
    logic               pipe_busy;

    logic [ALU_LAT-1:0] tag_v_q;
    logic [ALU_LAT-1:0] tag_v_d;
    logic [IW-1:0]      tag_id_q [ALU_LAT];
    logic [IW-1:0]      tag_id_d [ALU_LAT];

    assign grant_en  = (state_q == alu_pkg::ST_RUN);
    assign pipe_busy = |tag_v_q;
    assign req_ready = grant_oh;
    assign idle      = (state_q == alu_pkg::ST_IDLE);

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_valid),
        .advance      (grant_en),
        .grant_onehot (grant_oh),
        .grant_idx    (grant_idx)
    );

    // Next-state logic; re-enabling during drain wins over the empty check.
    always_comb begin
        state_d = state_q;
        case (state_q)
            alu_pkg::ST_IDLE: begin
                if (en) state_d = alu_pkg::ST_RUN;
            end
            alu_pkg::ST_RUN: begin
                if (!en) state_d = alu_pkg::ST_DRAIN;
            end
            alu_pkg::ST_DRAIN: begin
                if (en)              state_d = alu_pkg::ST_RUN;
                else if (!pipe_busy) state_d = alu_pkg::ST_IDLE;
            end
            default: state_d = alu_pkg::ST_IDLE;
        endcase
    end

    // Tag pipe shadows alu2 so each result is routed to its originator.
    always_comb begin
        tag_v_d[0]  = |grant_oh;
        tag_id_d[0] = grant_idx;
        for (int unsigned i = 1; i < ALU_LAT; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end
    end

    // State and tag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= alu_pkg::ST_IDLE;
            tag_v_q <= '0;
            for (int unsigned i = 0; i < ALU_LAT; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            tag_v_q <= tag_v_d;
            for (int unsigned i = 0; i < ALU_LAT; i++) begin
                tag_id_q[i] <= tag_id_d[i];
            end
        end
    end

    // Issue mux: granted slice, or a zeroed nop when nothing is granted.
    always_comb begin
        alu_in_valid = |grant_oh;
        alu_op       = alu_pkg::OP_NOP;
        alu_a        = '0;
        alu_b        = '0;
        if (|grant_oh) begin
            alu_op = req_op[32'(grant_idx)*OPW +: OPW];
            alu_a  = req_a[32'(grant_idx)*WIDTH +: WIDTH];
            alu_b  = req_b[32'(grant_idx)*WIDTH +: WIDTH];
        end
    end

    // Response decode from the last tag stage.
    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        if (tag_v_q[ALU_LAT-1]) begin
            resp_valid[tag_id_q[ALU_LAT-1]] = 1'b1;
            resp_data                       = alu_out;
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a behavioural alu2 stand-in and a response scoreboard.
module tb_alu_sched;
    import alu_pkg::*;

    localparam int unsigned W = 6;
    localparam int unsigned N = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           en    = 1'b0;
    logic [N-1:0]   req_valid;
    logic [2*N-1:0] req_op;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [W-1:0]   resp_data;
    logic           idle;
    logic [1:0]     alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           alu_in_valid;
    logic [W-1:0]   alu_out;

    logic [N-1:0]   vld_t;
    logic [1:0]     op_t [N];
    logic [W-1:0]   a_t  [N];
    logic [W-1:0]   b_t  [N];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int           id;
        logic [W-1:0] data;
        int           due;
    } exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_valid = vld_t;
        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2] = op_t[i];
            req_a[W*i +: W]  = a_t[i];
            req_b[W*i +: W]  = b_t[i];
        end
    end

    function automatic logic [W-1:0] calc(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        case (op)
            2'd1:    return a + b;
            2'd2:    return a - b;
            default: return '0;
        endcase
    endfunction

    // alu2 stand-in: input register then output register.
    logic [1:0]   s_op;
    logic [W-1:0] s_a;
    logic [W-1:0] s_b;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_op    <= '0;
            s_a     <= '0;
            s_b     <= '0;
            alu_out <= '0;
        end else begin
            s_op    <= alu_op;
            s_a     <= alu_a;
            s_b     <= alu_b;
            alu_out <= calc(s_op, s_a, s_b);
        end
    end

    alu_sched #(
        .WIDTH   (W),
        .NREQ    (N),
        .ALU_LAT (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .idle         (idle),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_in_valid (alu_in_valid),
        .alu_out      (alu_out)
    );

    task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        vld_t[i] = v;
        op_t[i]  = op;
        a_t[i]   = a;
        b_t[i]   = b;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(32'(req_ready),    32'd0, {tag, "_ready"});
        chk(32'(resp_valid),   32'd0, {tag, "_resp_valid"});
        chk(32'(resp_data),    32'd0, {tag, "_resp_data"});
        chk(32'(alu_in_valid), 32'd0, {tag, "_alu_in_valid"});
        chk(32'(alu_op),       32'd0, {tag, "_alu_op"});
        chk(32'(alu_a),        32'd0, {tag, "_alu_a"});
        chk(32'(alu_b),        32'd0, {tag, "_alu_b"});
        chk(32'(idle),         32'd1, {tag, "_idle"});
    endtask

    // One cycle: check grant/issue/idle mid-cycle, queue the expected response, step past the edge.
    task automatic step(input logic [N-1:0] er, input logic ei, input string tag);
        int g;
        @(negedge clk);
        chk(32'(req_ready),    32'(er),  {tag, "_ready"});
        chk(32'(idle),         32'(ei),  {tag, "_idle"});
        chk(32'(alu_in_valid), 32'(|er), {tag, "_in_valid"});
        g = -1;
        for (int i = 0; i < N; i++) if (er[i]) g = i;
        if (g >= 0) begin
            chk(32'(alu_op), 32'(op_t[g]), {tag, "_alu_op"});
            chk(32'(alu_a),  32'(a_t[g]),  {tag, "_alu_a"});
            chk(32'(alu_b),  32'(b_t[g]),  {tag, "_alu_b"});
            sb.push_back('{g, calc(op_t[g], a_t[g], b_t[g]), cyc + 2});
        end else begin
            chk(32'(alu_op), 32'd0, {tag, "_alu_op_nop"});
            chk(32'(alu_a),  32'd0, {tag, "_alu_a_zero"});
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: each expected result must appear exactly in its due cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t         e;
                logic [N-1:0] oh;
                e  = sb.pop_front();
                oh = N'(1) << e.id;
                chk(32'(resp_valid), 32'(oh),     "resp_valid");
                chk(32'(resp_data),  32'(e.data), "resp_data");
            end else begin
                chk(32'(resp_valid), 32'd0, "resp_quiet");
            end
        end
    end

    initial begin
        vld_t = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 2'd0, '0, '0);

        // Reset with a request pending and en high.
        set_req(0, 1'b1, OP_ADD, 6'd5, 6'd3);
        en = 1'b1;
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b0;

        step(4'b0000, 1'b1, "idle_en0");
        en = 1'b1;
        step(4'b0000, 1'b1, "idle_no_grant");

        // Single add, then wrap-around add and modular subtract.
        step(4'b0001, 1'b0, "single_add");
        set_req(0, 1'b1, OP_ADD, 6'd63, 6'd1);
        step(4'b0001, 1'b0, "wrap_add");
        set_req(0, 1'b0, OP_NOP, '0, '0);
        set_req(1, 1'b1, OP_SUB, 6'd2, 6'd5);
        step(4'b0010, 1'b0, "sub_wrap");

        // Fairness from ptr=2 with only req1 and req3 pending.
        set_req(1, 1'b1, OP_ADD, 6'd9, 6'd9);
        set_req(3, 1'b1, OP_SUB, 6'd0, 6'd1);
        step(4'b1000, 1'b0, "fair_r3");
        step(4'b0010, 1'b0, "fair_r1");
        set_req(1, 1'b0, OP_NOP, '0, '0);
        step(4'b1000, 1'b0, "fair_r3_again");

        // Round robin with all four requesting from ptr=0.
        set_req(0, 1'b1, OP_ADD, 6'd1,  6'd2);
        set_req(1, 1'b1, OP_SUB, 6'd10, 6'd4);
        set_req(2, 1'b1, OP_ADD, 6'd30, 6'd30);
        set_req(3, 1'b1, OP_NOP, 6'd7,  6'd7);
        step(4'b0001, 1'b0, "rr0");
        step(4'b0010, 1'b0, "rr1");
        step(4'b0100, 1'b0, "rr2");
        step(4'b1000, 1'b0, "rr3");
        step(4'b0001, 1'b0, "rr0_again");

        // Drain: en falls during a grant cycle, two ops in flight.
        en = 1'b0;
        step(4'b0010, 1'b0, "drain_last_grant");
        step(4'b0000, 1'b0, "drain_busy1");
        step(4'b0000, 1'b0, "drain_busy2");
        step(4'b0000, 1'b0, "drain_empty");
        step(4'b0000, 1'b1, "drain_idle");
        en = 1'b1;
        step(4'b0000, 1'b1, "rerun_idle");
        step(4'b0100, 1'b0, "rerun_grant");

        // Reset with ops in flight: tags dropped, no late responses.
        step(4'b1000, 1'b0, "pre_reset");
        rst_n = 1'b0;
        sb.delete();
        #2;
        check_reset_outputs("reset_mid");
        @(posedge clk);
        #1;
        vld_t = '0;
        rst_n = 1'b1;
        step(4'b0000, 1'b1, "post_reset_idle");
        step(4'b0000, 1'b0, "post_reset_run1");
        step(4'b0000, 1'b0, "post_reset_run2");
        step(4'b0000, 1'b0, "post_reset_run3");

        chk(32'(sb.size()), 32'd0, "scoreboard_empty");
        en = 1'b0;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
